// File: rtl/ft_fifo_arbiter.sv
// FT2232H 245-synchronous FIFO bus sequencer: grants the shared bus per burst to
// RX (host -> FIFO A) or TX (FIFO B -> host) and decodes the bus and FIFO strobes.
module ft_fifo_arbiter #(
   parameter int DW        = 8,
   parameter int MAX_BURST = 64,
   parameter int TURN_CYC  = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rxf_n,
   input  logic          txe_n,
   input  logic          ffa,
   input  logic          efb_n,
   input  logic [DW-1:0] ft_din,
   output logic [DW-1:0] ft_dout,
   output logic          ft_drive,
   output logic          ft_oe_n,
   output logic          ft_rd_n,
   output logic          ft_wr_n,
   output logic          fa_wr,
   output logic [DW-1:0] fa_data,
   output logic          fb_rd,
   input  logic [DW-1:0] fb_data,
   output logic          rx_busy,
   output logic          tx_busy
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam int TW = $clog2(TURN_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX_OE,
      S_RX_RD,
      S_TX,
      S_TURN
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [TW-1:0] turn_reg, turn_next;
   logic          last_grant_reg, last_grant_next;   // 1 = TX had the last grant

   logic          rx_ok, tx_ok;
   logic [CW-1:0] cnt_inc;
   logic          burst_last;

   assign rx_ok      = ~rxf_n & ~ffa;
   assign tx_ok      = ~txe_n & efb_n;
   assign cnt_inc    = cnt_reg + CW'(1);
   assign burst_last = (cnt_inc == CW'(MAX_BURST));

   assign ft_dout = fb_data;
   assign fa_data = ft_din;
   assign rx_busy = (state_reg == S_RX_OE) || (state_reg == S_RX_RD);
   assign tx_busy = (state_reg == S_TX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         cnt_reg        <= '0;
         turn_reg       <= '0;
         last_grant_reg <= 1'b1;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         turn_reg       <= turn_next;
         last_grant_reg <= last_grant_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      turn_next       = '0;
      last_grant_next = last_grant_reg;
      case (state_reg)
         S_IDLE: begin
            cnt_next = '0;
            if (rx_ok && (!tx_ok || last_grant_reg)) begin
               state_next      = S_RX_OE;
               last_grant_next = 1'b0;
            end else if (tx_ok) begin
               state_next      = S_TX;
               last_grant_next = 1'b1;
            end
         end
         S_RX_OE: state_next = S_RX_RD;
         S_RX_RD, S_TX: begin
            if ((state_reg == S_RX_RD) ? rx_ok : tx_ok) begin
               cnt_next = cnt_inc;
               if (burst_last) state_next = S_TURN;
            end else begin
               state_next = S_TURN;
            end
         end
         S_TURN: begin
            // The turnaround counter only advances here and is cleared everywhere else.
            if (turn_reg == TW'(TURN_CYC - 1)) state_next = S_IDLE;
            else turn_next = turn_reg + TW'(1);
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Strobes decode registered state with live flags; reset overrides them at once.
   always_comb begin
      ft_oe_n  = 1'b1;
      ft_rd_n  = 1'b1;
      ft_wr_n  = 1'b1;
      fa_wr    = 1'b0;
      fb_rd    = 1'b0;
      ft_drive = 1'b0;
      if (!rst) begin
         case (state_reg)
            S_RX_OE: ft_oe_n = 1'b0;
            S_RX_RD: begin
               ft_oe_n = 1'b0;
               ft_rd_n = ~rx_ok;
               fa_wr   = rx_ok;
            end
            S_TX: begin
               ft_drive = 1'b1;
               ft_wr_n  = ~tx_ok;
               fb_rd    = tx_ok;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ft_fifo_arbiter.sv
// Directed bench for ft_fifo_arbiter: one default instance plus one with
// MAX_BURST=4 for the round-robin burst alternation scenario.
module tb_ft_fifo_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxf_n, txe_n, ffa, efb_n;
   logic [7:0] ft_din, fb_data;

   logic [7:0] ft_dout, fa_data;
   logic       ft_drive, ft_oe_n, ft_rd_n, ft_wr_n, fa_wr, fb_rd, rx_busy, tx_busy;

   logic [7:0] ft_dout_4, fa_data_4;
   logic       ft_drive_4, ft_oe_n_4, ft_rd_n_4, ft_wr_n_4, fa_wr_4, fb_rd_4;
   logic       rx_busy_4, tx_busy_4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ft_fifo_arbiter #(.DW(8), .MAX_BURST(64), .TURN_CYC(1)) dut (
      .clk(clk), .rst(rst), .rxf_n(rxf_n), .txe_n(txe_n), .ffa(ffa), .efb_n(efb_n),
      .ft_din(ft_din), .ft_dout(ft_dout), .ft_drive(ft_drive), .ft_oe_n(ft_oe_n),
      .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n), .fa_wr(fa_wr), .fa_data(fa_data),
      .fb_rd(fb_rd), .fb_data(fb_data), .rx_busy(rx_busy), .tx_busy(tx_busy)
   );

   ft_fifo_arbiter #(.DW(8), .MAX_BURST(4), .TURN_CYC(1)) dut4 (
      .clk(clk), .rst(rst), .rxf_n(rxf_n), .txe_n(txe_n), .ffa(ffa), .efb_n(efb_n),
      .ft_din(ft_din), .ft_dout(ft_dout_4), .ft_drive(ft_drive_4), .ft_oe_n(ft_oe_n_4),
      .ft_rd_n(ft_rd_n_4), .ft_wr_n(ft_wr_n_4), .fa_wr(fa_wr_4), .fa_data(fa_data_4),
      .fb_rd(fb_rd_4), .fb_data(fb_data), .rx_busy(rx_busy_4), .tx_busy(tx_busy_4)
   );

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rxf_n   = 1'b1;
      txe_n   = 1'b1;
      ffa     = 1'b0;
      efb_n   = 1'b0;
      ft_din  = 8'h00;
      fb_data = 8'h00;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      idle_inputs();
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      rxf_n = 1'b0; txe_n = 1'b0; efb_n = 1'b1;
      next_cycle();
      next_cycle();
      #1;
      n_cmp++;
      if ({ft_oe_n, ft_rd_n, ft_wr_n, fa_wr, fb_rd, ft_drive} !== 6'b111000) begin
         n_err++;
         $display("FAIL reset_strobes: got oe,rd,wr,fa_wr,fb_rd,drive=%b want 111000",
                  {ft_oe_n, ft_rd_n, ft_wr_n, fa_wr, fb_rd, ft_drive});
      end
      n_cmp++;
      if ({rx_busy, tx_busy} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_busy: got %b want 00", {rx_busy, tx_busy});
      end
      rst = 1'b0;
      idle_inputs();
      #1;
      n_cmp++;
      if ({ft_oe_n, ft_rd_n, ft_wr_n, fa_wr, fb_rd, ft_drive} !== 6'b111000) begin
         n_err++;
         $display("FAIL reset_release_idle: got %b want 111000",
                  {ft_oe_n, ft_rd_n, ft_wr_n, fa_wr, fb_rd, ft_drive});
      end
   endtask

   task automatic test_rx_burst();
      int pulses = 0;
      apply_reset();
      rxf_n = 1'b0;
      #1;
      n_cmp++;
      if ({ft_oe_n, ft_rd_n, rx_busy} !== 3'b110) begin
         n_err++;
         $display("FAIL rx_idle_cycle: got oe,rd,busy=%b want 110", {ft_oe_n, ft_rd_n, rx_busy});
      end
      next_cycle();
      n_cmp++;
      if ({ft_oe_n, ft_rd_n, fa_wr, rx_busy} !== 4'b0101) begin
         n_err++;
         $display("FAIL rx_oe_lead: got oe,rd,fa_wr,busy=%b want 0101",
                  {ft_oe_n, ft_rd_n, fa_wr, rx_busy});
      end
      for (int k = 0; k < 10; k++) begin
         next_cycle();
         ft_din = 8'(k);
         #1;
         if (fa_wr === 1'b1) pulses++;
         n_cmp++;
         if ({ft_oe_n, ft_rd_n, fa_wr} !== 3'b001 || fa_data !== 8'(k)) begin
            n_err++;
            $display("FAIL rx_xfer_%0d: got oe,rd,fa_wr=%b data=%h want 001 data=%h",
                     k, {ft_oe_n, ft_rd_n, fa_wr}, fa_data, 8'(k));
         end
      end
      n_cmp++;
      if (pulses !== 10) begin
         n_err++;
         $display("FAIL rx_pulse_count: got %0d want 10", pulses);
      end
      next_cycle();
      rxf_n = 1'b1;
      #1;
      n_cmp++;
      if ({ft_oe_n, ft_rd_n, fa_wr, rx_busy} !== 4'b0101) begin
         n_err++;
         $display("FAIL rx_flag_drop: got oe,rd,fa_wr,busy=%b want 0101",
                  {ft_oe_n, ft_rd_n, fa_wr, rx_busy});
      end
      // Flag returns during TURN: it must not restart the burst without a new grant.
      next_cycle();
      rxf_n = 1'b0;
      #1;
      n_cmp++;
      if ({ft_oe_n, ft_rd_n, fa_wr, rx_busy} !== 4'b1100) begin
         n_err++;
         $display("FAIL rx_turn: got oe,rd,fa_wr,busy=%b want 1100",
                  {ft_oe_n, ft_rd_n, fa_wr, rx_busy});
      end
      next_cycle();
      n_cmp++;
      if ({ft_oe_n, ft_rd_n, rx_busy} !== 3'b110) begin
         n_err++;
         $display("FAIL rx_idle_after_turn: got oe,rd,busy=%b want 110", {ft_oe_n, ft_rd_n, rx_busy});
      end
      next_cycle();
      n_cmp++;
      if ({ft_oe_n, ft_rd_n, rx_busy} !== 3'b011) begin
         n_err++;
         $display("FAIL rx_regrant: got oe,rd,busy=%b want 011", {ft_oe_n, ft_rd_n, rx_busy});
      end
      idle_inputs();
   endtask

   task automatic test_tx_burst();
      apply_reset();
      txe_n = 1'b0; efb_n = 1'b1; fb_data = 8'hA0;
      #1;
      n_cmp++;
      if ({ft_wr_n, fb_rd, ft_drive, tx_busy} !== 4'b1000) begin
         n_err++;
         $display("FAIL tx_idle_cycle: got wr,fb_rd,drive,busy=%b want 1000",
                  {ft_wr_n, fb_rd, ft_drive, tx_busy});
      end
      for (int k = 0; k < 5; k++) begin
         if (k > 0) next_cycle();
         fb_data = 8'hA0 + 8'(k);
         if (k == 0) next_cycle();
         #1;
         n_cmp++;
         if ({ft_wr_n, fb_rd, ft_drive, ft_oe_n, tx_busy} !== 5'b01111 || ft_dout !== 8'hA0 + 8'(k)) begin
            n_err++;
            $display("FAIL tx_xfer_%0d: got wr,fb_rd,drive,oe,busy=%b dout=%h want 01111 dout=%h",
                     k, {ft_wr_n, fb_rd, ft_drive, ft_oe_n, tx_busy}, ft_dout, 8'hA0 + 8'(k));
         end
      end
      next_cycle();
      efb_n = 1'b0;
      #1;
      n_cmp++;
      if ({ft_wr_n, fb_rd, ft_drive} !== 3'b101) begin
         n_err++;
         $display("FAIL tx_empty_drop: got wr,fb_rd,drive=%b want 101", {ft_wr_n, fb_rd, ft_drive});
      end
      next_cycle();
      n_cmp++;
      if ({ft_wr_n, fb_rd, ft_drive, tx_busy} !== 4'b1000) begin
         n_err++;
         $display("FAIL tx_turn: got wr,fb_rd,drive,busy=%b want 1000", {ft_wr_n, fb_rd, ft_drive, tx_busy});
      end
      idle_inputs();
   endtask

   task automatic test_ffa_stop();
      int pulses = 0;
      apply_reset();
      rxf_n = 1'b0;
      next_cycle();                 // RX_OE
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         ft_din = 8'h10 + 8'(k);
         if (k == 3) ffa = 1'b1;
         #1;
         if (fa_wr === 1'b1) pulses++;
      end
      n_cmp++;
      if ({ft_oe_n, ft_rd_n, fa_wr} !== 3'b010) begin
         n_err++;
         $display("FAIL ffa_drop: got oe,rd,fa_wr=%b want 010", {ft_oe_n, ft_rd_n, fa_wr});
      end
      n_cmp++;
      if (pulses !== 3) begin
         n_err++;
         $display("FAIL ffa_pulse_count: got %0d want 3", pulses);
      end
      next_cycle();
      n_cmp++;
      if ({ft_oe_n, ft_rd_n, fa_wr, rx_busy} !== 4'b1100) begin
         n_err++;
         $display("FAIL ffa_turn: got oe,rd,fa_wr,busy=%b want 1100", {ft_oe_n, ft_rd_n, fa_wr, rx_busy});
      end
      idle_inputs();
   endtask

   task automatic test_txe_stop();
      apply_reset();
      txe_n = 1'b0; efb_n = 1'b1;
      next_cycle();                 // TX transfer 1
      next_cycle();                 // TX transfer 2
      next_cycle();
      txe_n = 1'b1;
      #1;
      n_cmp++;
      if ({ft_wr_n, fb_rd, ft_drive, tx_busy} !== 4'b1011) begin
         n_err++;
         $display("FAIL txe_drop: got wr,fb_rd,drive,busy=%b want 1011", {ft_wr_n, fb_rd, ft_drive, tx_busy});
      end
      next_cycle();
      txe_n = 1'b0;
      #1;
      n_cmp++;
      if ({ft_wr_n, fb_rd, ft_drive, tx_busy} !== 4'b1000) begin
         n_err++;
         $display("FAIL txe_turn: got wr,fb_rd,drive,busy=%b want 1000", {ft_wr_n, fb_rd, ft_drive, tx_busy});
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_rx();
      apply_reset();
      rxf_n = 1'b0;
      next_cycle();                 // RX_OE
      next_cycle();                 // byte 1
      next_cycle();                 // byte 2
      next_cycle();
      rst = 1'b1;                   // byte 3 cycle
      #1;
      n_cmp++;
      if ({ft_oe_n, ft_rd_n, fa_wr} !== 3'b110) begin
         n_err++;
         $display("FAIL rst_mid_rx: got oe,rd,fa_wr=%b want 110", {ft_oe_n, ft_rd_n, fa_wr});
      end
      next_cycle();
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({ft_oe_n, ft_rd_n, fa_wr, rx_busy} !== 4'b1100) begin
         n_err++;
         $display("FAIL rst_mid_rx_idle: got oe,rd,fa_wr,busy=%b want 1100",
                  {ft_oe_n, ft_rd_n, fa_wr, rx_busy});
      end
      next_cycle();
      n_cmp++;
      if ({ft_oe_n, ft_rd_n, fa_wr} !== 3'b010) begin
         n_err++;
         $display("FAIL rst_mid_rx_regrant: got oe,rd,fa_wr=%b want 010", {ft_oe_n, ft_rd_n, fa_wr});
      end
      idle_inputs();
   endtask

   // Codes: 0 no strobe (IDLE/TURN), 1 RX_OE, 2 RX transfer, 3 TX transfer.
   task automatic test_arbitration();
      int exp_arb [0:25];
      int code;
      exp_arb = '{0, 1, 2, 2, 2, 2, 0, 0, 3, 3, 3, 3, 0,
                  0, 1, 2, 2, 2, 2, 0, 0, 3, 3, 3, 3, 0};
      apply_reset();
      rxf_n = 1'b0; ffa = 1'b0; txe_n = 1'b0; efb_n = 1'b1;
      for (int c = 0; c < 26; c++) begin
         if (c > 0) next_cycle();
         #1;
         code = exp_arb[c];
         n_cmp++;
         if (ft_oe_n_4 !== !(code == 1 || code == 2) || ft_rd_n_4 !== !(code == 2) ||
             fa_wr_4 !== (code == 2) || ft_wr_n_4 !== !(code == 3) ||
             fb_rd_4 !== (code == 3) || ft_drive_4 !== (code == 3)) begin
            n_err++;
            $display("FAIL arb_cycle_%0d: got oe,rd,fa_wr,wr,fb_rd,drive=%b want code %0d",
                     c, {ft_oe_n_4, ft_rd_n_4, fa_wr_4, ft_wr_n_4, fb_rd_4, ft_drive_4}, code);
         end
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_rx_burst();
      test_tx_burst();
      test_ffa_stop();
      test_txe_stop();
      test_reset_mid_rx();
      test_arbitration();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
